lshifdn_rx: RTL

Receive-side companion of the up-direction level shifter. Takes signals arriving from the high-voltage (5V) domain through down-shift cells into the 3.3V core and synchronises them. It glitch-filters each bit and flags edges. An isolation FSM clamps outputs to a safe value whenever the far domain's power-good is low, and after power-good returns it holds the clamp for a settle window before releasing.

---
 rtl/lshifdn_rx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/lshifdn_rx.sv
// lshifdn_rx: receive side of the 5V -> 3.3V level-shift crossing.
// Synchronises the down-shifted data and the far-domain power-good,
// glitch-filters each data bit, flags edges, and clamps the outputs
// while the far domain is unpowered or still settling.
//
// Handshake note: this block has no valid/ready pair. READY simply
// reports that the isolation FSM is in PASS, i.e. Y is live data; ISO
// is its complement and says Y is held at CLAMP_VAL.
module lshifdn_rx #(
  parameter int              WIDTH         = 4,
  parameter int              SYNC_STAGES   = 2,
  parameter int              SETTLE_CYCLES = 8,
  parameter int              FILT_CYCLES   = 3,
  parameter logic [WIDTH-1:0] CLAMP_VAL    = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic             PWRGD,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             ISO,
  output logic             READY,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_CLAMP  = 2'd0,
    S_SETTLE = 2'd1,
    S_PASS   = 2'd2
  } state_t;

  state_t           state;
  logic [SW-1:0]    settle_cnt;
  logic [CW-1:0]    cnt [WIDTH];

  logic [WIDTH-1:0] a_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] pg_sync;
  logic [WIDTH-1:0] a_s;
  logic             pg_s;

  assign a_s  = a_sync[SYNC_STAGES-1];
  assign pg_s = pg_sync[SYNC_STAGES-1];

  // Flop chains bringing A and PWRGD into the CLK domain; nothing else
  // looks at the raw asynchronous inputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < SYNC_STAGES; s++) a_sync[s] <= '0;
      pg_sync <= '0;
    end else begin
      a_sync[0] <= A;
      for (int s = 1; s < SYNC_STAGES; s++) a_sync[s] <= a_sync[s-1];
      pg_sync <= {pg_sync[SYNC_STAGES-2:0], PWRGD};
    end
  end

  // Isolation FSM plus per-bit filter; all outputs are registered here.
  // Loss of power-good always wins over a filter update in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_CLAMP;
      settle_cnt <= '0;
      Y          <= CLAMP_VAL;
      RISE       <= '0;
      FALL       <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      RISE <= '0;
      FALL <= '0;
      case (state)
        S_CLAMP: begin
          Y <= CLAMP_VAL;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
          if (pg_s) begin
            state      <= S_SETTLE;
            settle_cnt <= SW'(SETTLE_CYCLES - 1);
          end
        end
        S_SETTLE: begin
          Y <= CLAMP_VAL;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
          if (!pg_s) begin
            state <= S_CLAMP;
          end else if (settle_cnt == '0) begin
            // Release: Y takes the synchronised data directly, no edge pulses.
            state <= S_PASS;
            Y     <= a_s;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        S_PASS: begin
          if (!pg_s) begin
            state <= S_CLAMP;
            Y     <= CLAMP_VAL;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
          end else begin
            for (int i = 0; i < WIDTH; i++) begin
              if (a_s[i] != Y[i]) begin
                if (cnt[i] == CW'(FILT_CYCLES - 1)) begin
                  // Mismatch persisted long enough: accept the new level.
                  Y[i]    <= a_s[i];
                  cnt[i]  <= '0;
                  RISE[i] <= a_s[i];
                  FALL[i] <= ~a_s[i];
                end else begin
                  cnt[i] <= cnt[i] + CW'(1);
                end
              end else begin
                cnt[i] <= '0;
              end
            end
          end
        end
        default: begin
          state <= S_CLAMP;
          Y     <= CLAMP_VAL;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end
      endcase
    end
  end

  assign ISO       = (state != S_PASS);
  assign READY     = (state == S_PASS);
  assign dbg_state = state;

endmodule
